// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side hazard request and pipeline-control response bundle for pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
  parameter int RF_SIZE = 5,
  parameter int CNT_W   = 16
);
  logic               id_valid;
  logic [RF_SIZE-1:0] id_rs1;
  logic [RF_SIZE-1:0] id_rs2;
  logic               id_use_rs1;
  logic               id_use_rs2;
  logic [RF_SIZE-1:0] id_rd;
  logic               id_reg_write;
  logic               id_load;
  logic               id_multi;
  logic               ex_branch_taken;
  logic               mc_done;

  logic               pc_en;
  logic               ir_en;
  logic               id_bubble;
  logic               flush_ifid;
  logic               ex_hold;
  logic [1:0]         fwd_a_sel;
  logic [1:0]         fwd_b_sel;
  logic [CNT_W-1:0]   stall_count;
  logic [CNT_W-1:0]   flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_load, id_multi, ex_branch_taken, mc_done,
    input  pc_en, ir_en, id_bubble, flush_ifid, ex_hold, fwd_a_sel, fwd_b_sel,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_rd,
           id_reg_write, id_load, id_multi, ex_branch_taken, mc_done,
    output pc_en, ir_en, id_bubble, flush_ifid, ex_hold, fwd_a_sel, fwd_b_sel,
           stall_count, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage core: tracks EX/MEM/WB destination tags,
// resolves load-use stalls, multi-cycle EX waits, taken-branch flushes and forwarding.
module pipe_hazard_ctrl #(
  parameter int RF_SIZE    = 5,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] LS_N = 2'(LOAD_STALL);

  typedef struct packed {
    logic               vld;
    logic [RF_SIZE-1:0] rs1;
    logic [RF_SIZE-1:0] rs2;
    logic [RF_SIZE-1:0] rd;
    logic               wr;
    logic               ld;
    logic               mu;
  } ex_tag_t;

  typedef struct packed {
    logic [RF_SIZE-1:0] rd;
    logic               wr;
    logic               ld;
  } mem_tag_t;

  typedef struct packed {
    logic [RF_SIZE-1:0] rd;
    logic               wr;
  } wb_tag_t;

  typedef enum logic [1:0] {RUN, LD_STALL, MC_WAIT, FLUSH} st_t;

  st_t              st_q, st_d, st_c;
  logic [1:0]       cnt_q, cnt_d;
  ex_tag_t          ex_q, ex_d;
  mem_tag_t         mem_q, mem_d;
  wb_tag_t          wb_q, wb_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;

  logic       hit_ex, hit_mem, lu_d1, lu_d2, mc_busy;
  logic [1:0] need;
  logic       pc_en_c, ir_en_c, bub_c, flush_c, hold_c;
  logic [1:0] fwd_a, fwd_b;

  // Unused sources are stored as x0 in the EX tag, so they can never match a producer.
  function automatic logic [1:0] fwd_sel(input logic [RF_SIZE-1:0] src,
                                         input mem_tag_t m, input wb_tag_t w);
    logic [1:0] s;
    s = 2'd0;
    if (m.wr && !m.ld && (m.rd != '0) && (m.rd == src)) s = 2'd1;
    else if (w.wr && (w.rd != '0) && (w.rd == src))    s = 2'd2;
    return s;
  endfunction

  assign fwd_a = fwd_sel(ex_q.rs1, mem_q, wb_q);
  assign fwd_b = fwd_sel(ex_q.rs2, mem_q, wb_q);

  assign hit_ex  = (ex_q.rd != '0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == ex_q.rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == ex_q.rd)));
  assign hit_mem = (mem_q.rd != '0) &&
                   ((bus.id_use_rs1 && (bus.id_rs1 == mem_q.rd)) ||
                    (bus.id_use_rs2 && (bus.id_rs2 == mem_q.rd)));
  assign lu_d1   = bus.id_valid && ex_q.vld && ex_q.ld && hit_ex;
  assign lu_d2   = (LOAD_STALL == 2) && bus.id_valid && mem_q.ld && hit_mem;
  assign need    = lu_d1 ? LS_N : 2'd1;
  assign mc_busy = ex_q.vld && ex_q.mu && !bus.mc_done;

  // A taken branch is resolved by the EX instruction; it cannot coexist with a held multi op.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    pc_en_c = 1'b1;
    ir_en_c = 1'b1;
    bub_c   = 1'b0;
    flush_c = 1'b0;
    hold_c  = 1'b0;
    st_c    = (bus.ex_branch_taken && (st_q != MC_WAIT)) ? FLUSH : st_q;
    case (st_c)
      FLUSH: begin
        flush_c = 1'b1;
        bub_c   = 1'b1;
        cnt_d   = 2'd0;
        st_d    = RUN;
      end
      LD_STALL: begin
        pc_en_c = 1'b0;
        ir_en_c = 1'b0;
        bub_c   = 1'b1;
        cnt_d   = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
        if (cnt_q <= 2'd1) st_d = RUN;
      end
      default: begin
        st_d = RUN;
        if (mc_busy) begin
          pc_en_c = 1'b0;
          ir_en_c = 1'b0;
          hold_c  = 1'b1;
          st_d    = MC_WAIT;
        end else if (lu_d1 || lu_d2) begin
          pc_en_c = 1'b0;
          ir_en_c = 1'b0;
          bub_c   = 1'b1;
          cnt_d   = need - 2'd1;
          if (need > 2'd1) st_d = LD_STALL;
        end
      end
    endcase
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = '0;
    wb_d  = '{rd: mem_q.rd, wr: mem_q.wr};
    if (!hold_c) begin
      mem_d = '{rd: ex_q.rd, wr: ex_q.vld && ex_q.wr, ld: ex_q.vld && ex_q.ld};
      ex_d  = '0;
      if (bus.id_valid && !bub_c && !flush_c) begin
        ex_d.vld = 1'b1;
        ex_d.rs1 = bus.id_use_rs1 ? bus.id_rs1 : '0;
        ex_d.rs2 = bus.id_use_rs2 ? bus.id_rs2 : '0;
        ex_d.rd  = bus.id_rd;
        ex_d.wr  = bus.id_reg_write;
        ex_d.ld  = bus.id_load;
        ex_d.mu  = bus.id_multi;
      end
    end
  end

  assign stall_d = stall_q + CNT_W'(!pc_en_c && (stall_q != '1));
  assign flush_d = flush_q + CNT_W'(flush_c && (flush_q != '1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Outputs are forced to free-running values while reset is held, independent of inputs.
  assign bus.pc_en       = !rst || pc_en_c;
  assign bus.ir_en       = !rst || ir_en_c;
  assign bus.id_bubble   = rst && bub_c;
  assign bus.flush_ifid  = rst && flush_c;
  assign bus.ex_hold     = rst && hold_c;
  assign bus.fwd_a_sel   = rst ? fwd_a : 2'd0;
  assign bus.fwd_b_sel   = rst ? fwd_b : 2'd0;
  assign bus.stall_count = stall_q;
  assign bus.flush_count = flush_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Drives three controller configurations (LOAD_STALL=1, LOAD_STALL=2, CNT_W=4) with shared
// decode stimulus and checks them against an instruction-level pipeline model.
module tb_pipe_hazard_ctrl;
  localparam int RF = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.RF_SIZE(RF), .CNT_W(16)) if0 ();
  pipe_hazard_ctrl_if #(.RF_SIZE(RF), .CNT_W(16)) if1 ();
  pipe_hazard_ctrl_if #(.RF_SIZE(RF), .CNT_W(4))  if2 ();

  assign if1.id_valid = if0.id_valid;         assign if2.id_valid = if0.id_valid;
  assign if1.id_rs1 = if0.id_rs1;             assign if2.id_rs1 = if0.id_rs1;
  assign if1.id_rs2 = if0.id_rs2;             assign if2.id_rs2 = if0.id_rs2;
  assign if1.id_use_rs1 = if0.id_use_rs1;     assign if2.id_use_rs1 = if0.id_use_rs1;
  assign if1.id_use_rs2 = if0.id_use_rs2;     assign if2.id_use_rs2 = if0.id_use_rs2;
  assign if1.id_rd = if0.id_rd;               assign if2.id_rd = if0.id_rd;
  assign if1.id_reg_write = if0.id_reg_write; assign if2.id_reg_write = if0.id_reg_write;
  assign if1.id_load = if0.id_load;           assign if2.id_load = if0.id_load;
  assign if1.id_multi = if0.id_multi;         assign if2.id_multi = if0.id_multi;
  assign if1.ex_branch_taken = if0.ex_branch_taken;
  assign if2.ex_branch_taken = if0.ex_branch_taken;
  assign if1.mc_done = if0.mc_done;           assign if2.mc_done = if0.mc_done;

  pipe_hazard_ctrl #(.RF_SIZE(RF), .LOAD_STALL(1), .CNT_W(16)) u_ls1 (.clk(clk), .rst(rst), .bus(if0.slave));
  pipe_hazard_ctrl #(.RF_SIZE(RF), .LOAD_STALL(2), .CNT_W(16)) u_ls2 (.clk(clk), .rst(rst), .bus(if1.slave));
  pipe_hazard_ctrl #(.RF_SIZE(RF), .LOAD_STALL(1), .CNT_W(4))  u_c4  (.clk(clk), .rst(rst), .bus(if2.slave));

  logic [8:0]  ctl [3];
  logic [15:0] sc  [3];
  logic [15:0] fc  [3];
  assign ctl[0] = {if0.pc_en, if0.ir_en, if0.id_bubble, if0.flush_ifid, if0.ex_hold, if0.fwd_a_sel, if0.fwd_b_sel};
  assign ctl[1] = {if1.pc_en, if1.ir_en, if1.id_bubble, if1.flush_ifid, if1.ex_hold, if1.fwd_a_sel, if1.fwd_b_sel};
  assign ctl[2] = {if2.pc_en, if2.ir_en, if2.id_bubble, if2.flush_ifid, if2.ex_hold, if2.fwd_a_sel, if2.fwd_b_sel};
  assign sc[0] = if0.stall_count; assign sc[1] = if1.stall_count; assign sc[2] = {12'd0, if2.stall_count};
  assign fc[0] = if0.flush_count; assign fc[1] = if1.flush_count; assign fc[2] = {12'd0, if2.flush_count};

  int total = 0;
  int bad   = 0;

  // ---------------- reference model: instructions occupying EX/MEM/WB ----------------
  typedef struct {
    bit v, u1, u2, rw, ld, mu;
    int rs1, rs2, rd;
  } ins_t;

  ins_t m_ex [3], m_mem [3], m_wb [3];
  ins_t cur;
  int   stall_left [3], sl_nxt [3];
  bit   mc_wait [3];
  int   stall_n [3], flush_n [3];
  bit   e_pc [3], e_bub [3], e_fl [3], e_hold [3];
  logic [8:0] e_ctl [3];

  function automatic int ls_of(int d);   return (d == 1) ? 2 : 1;  endfunction
  function automatic int cw_of(int d);   return (d == 2) ? 4 : 16; endfunction
  function automatic int sat(int n, int cw);
    int mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction
  function automatic bit reads(ins_t i, int r);
    return (r != 0) && ((i.u1 && i.rs1 == r) || (i.u2 && i.rs2 == r));
  endfunction
  function automatic int fsel(ins_t mm, ins_t wb, bit used, int src);
    if (!used) return 0;
    if (mm.v && mm.rw && !mm.ld && mm.rd != 0 && mm.rd == src) return 1;
    if (wb.v && wb.rw && wb.rd != 0 && wb.rd == src) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    ins_t inv = '{default: 0};
    for (int d = 0; d < 3; d++) begin
      m_ex[d] = inv; m_mem[d] = inv; m_wb[d] = inv;
      stall_left[d] = 0; mc_wait[d] = 0; stall_n[d] = 0; flush_n[d] = 0;
    end
  endtask

  task automatic model_eval();
    cur.v = if0.id_valid; cur.u1 = if0.id_use_rs1; cur.u2 = if0.id_use_rs2;
    cur.rw = if0.id_reg_write; cur.ld = if0.id_load; cur.mu = if0.id_multi;
    cur.rs1 = int'(if0.id_rs1); cur.rs2 = int'(if0.id_rs2); cur.rd = int'(if0.id_rd);
    for (int d = 0; d < 3; d++) begin
      bit lu1, lu2, pc, bub, fl, hold;
      int need, fa, fb;
      lu1  = cur.v && m_ex[d].v && m_ex[d].ld && reads(cur, m_ex[d].rd);
      lu2  = (ls_of(d) == 2) && cur.v && m_mem[d].v && m_mem[d].ld && reads(cur, m_mem[d].rd);
      need = lu1 ? ls_of(d) : (lu2 ? 1 : 0);
      pc = 1; bub = 0; fl = 0; hold = 0; sl_nxt[d] = stall_left[d];
      if (if0.ex_branch_taken && !mc_wait[d]) begin
        fl = 1; bub = 1; sl_nxt[d] = 0;
      end else if (stall_left[d] > 0) begin
        pc = 0; bub = 1; sl_nxt[d] = stall_left[d] - 1;
      end else if (m_ex[d].v && m_ex[d].mu && !if0.mc_done) begin
        pc = 0; hold = 1;
      end else if (need > 0) begin
        pc = 0; bub = 1; sl_nxt[d] = need - 1;
      end
      fa = fsel(m_mem[d], m_wb[d], m_ex[d].v && m_ex[d].u1, m_ex[d].rs1);
      fb = fsel(m_mem[d], m_wb[d], m_ex[d].v && m_ex[d].u2, m_ex[d].rs2);
      e_pc[d] = pc; e_bub[d] = bub; e_fl[d] = fl; e_hold[d] = hold;
      e_ctl[d] = {pc, pc, bub, fl, hold, 2'(fa), 2'(fb)};
    end
  endtask

  task automatic model_commit();
    ins_t inv = '{default: 0};
    for (int d = 0; d < 3; d++) begin
      stall_n[d] += int'(!e_pc[d]);
      flush_n[d] += int'(e_fl[d]);
      m_wb[d] = m_mem[d];
      if (e_hold[d]) m_mem[d] = inv;
      else begin
        m_mem[d] = m_ex[d];
        m_ex[d]  = (cur.v && !e_bub[d] && !e_fl[d]) ? cur : inv;
      end
      mc_wait[d]    = e_hold[d];
      stall_left[d] = sl_nxt[d];
    end
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                        input int rd, input bit rw, input bit ld, input bit mu);
    if0.id_valid = v; if0.id_rs1 = RF'(rs1); if0.id_use_rs1 = u1;
    if0.id_rs2 = RF'(rs2); if0.id_use_rs2 = u2; if0.id_rd = RF'(rd);
    if0.id_reg_write = rw; if0.id_load = ld; if0.id_multi = mu;
  endtask
  task automatic nop();  set_id(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic settle(); #2; model_eval(); endtask
  task automatic tick(); model_commit(); @(posedge clk); #1; endtask
  task automatic do_reset();
    rst = 1'b0; nop(); if0.ex_branch_taken = 0; if0.mc_done = 0;
    model_reset();
    @(posedge clk); #1; rst = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; nop(); if0.ex_branch_taken = 1; if0.mc_done = 0;
    repeat (2) @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      total++; if (ctl[d] !== 9'b110000000) begin bad++; $display("FAIL reset_ctl[%0d] got=%b exp=110000000", d, ctl[d]); end
      total++; if (sc[d] !== 16'd0) begin bad++; $display("FAIL reset_stall[%0d] got=%0d exp=0", d, sc[d]); end
      total++; if (fc[d] !== 16'd0) begin bad++; $display("FAIL reset_flush[%0d] got=%0d exp=0", d, fc[d]); end
    end
    if0.ex_branch_taken = 0;
    model_reset(); rst = 1'b1;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_id(1, 1, 1, 2, 1, 8, 1, 0, 1); settle(); tick();
    nop(); settle(); tick();
    settle();
    total++; if (if0.ex_hold !== 1'b1 || if0.pc_en !== 1'b0) begin bad++; $display("FAIL midwait_pre hold=%b pc=%b exp hold=1 pc=0", if0.ex_hold, if0.pc_en); end
    total++; if (sc[0] !== 16'd1) begin bad++; $display("FAIL midwait_pre_cnt got=%0d exp=1", sc[0]); end
    rst = 1'b0; #1;
    total++; if (if0.pc_en !== 1'b1 || if0.ex_hold !== 1'b0) begin bad++; $display("FAIL midwait_rst hold=%b pc=%b exp hold=0 pc=1", if0.ex_hold, if0.pc_en); end
    total++; if (sc[0] !== 16'd0) begin bad++; $display("FAIL midwait_rst_cnt got=%0d exp=0", sc[0]); end
    model_reset();
    @(posedge clk); #1; rst = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); settle(); tick();        // lw x5
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); settle();                // add x6,x5,x1
    total++; if (if0.pc_en !== 1'b0 || if0.id_bubble !== 1'b1) begin bad++; $display("FAIL lu1_c1 pc=%b bub=%b exp pc=0 bub=1", if0.pc_en, if0.id_bubble); end
    total++; if (if1.pc_en !== 1'b0 || if1.id_bubble !== 1'b1) begin bad++; $display("FAIL lu2_c1 pc=%b bub=%b exp pc=0 bub=1", if1.pc_en, if1.id_bubble); end
    tick(); settle();
    total++; if (if0.pc_en !== 1'b1 || if0.id_bubble !== 1'b0) begin bad++; $display("FAIL lu1_c2 pc=%b bub=%b exp pc=1 bub=0", if0.pc_en, if0.id_bubble); end
    total++; if (if1.pc_en !== 1'b0 || if1.id_bubble !== 1'b1) begin bad++; $display("FAIL lu2_c2 pc=%b bub=%b exp pc=0 bub=1", if1.pc_en, if1.id_bubble); end
    tick(); nop(); settle();
    total++; if (if0.fwd_a_sel !== 2'd2) begin bad++; $display("FAIL lu1_fwd got=%0d exp=2", if0.fwd_a_sel); end
    total++; if (sc[0] !== 16'd1) begin bad++; $display("FAIL lu1_cnt got=%0d exp=1", sc[0]); end
    total++; if (sc[1] !== 16'd2) begin bad++; $display("FAIL lu2_cnt got=%0d exp=2", sc[1]); end
    tick();
  endtask

  task automatic test_load_gap();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); settle(); tick();        // lw x5
    set_id(1, 2, 1, 3, 1, 7, 1, 0, 0); settle(); tick();        // add x7,x2,x3
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); settle();                // add x6,x5,x1
    total++; if (if1.pc_en !== 1'b0 || if1.id_bubble !== 1'b1) begin bad++; $display("FAIL gap_ls2 pc=%b bub=%b exp pc=0 bub=1", if1.pc_en, if1.id_bubble); end
    total++; if (if0.pc_en !== 1'b1) begin bad++; $display("FAIL gap_ls1 pc=%b exp=1", if0.pc_en); end
    tick(); settle();
    total++; if (if1.pc_en !== 1'b1) begin bad++; $display("FAIL gap_ls2_done pc=%b exp=1", if1.pc_en); end
    tick(); nop(); settle();
    total++; if (sc[1] !== 16'd1) begin bad++; $display("FAIL gap_cnt got=%0d exp=1", sc[1]); end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); settle(); tick();        // add x3
    set_id(1, 3, 1, 4, 1, 9, 1, 0, 0); settle(); tick();        // uses x3
    nop(); settle();
    total++; if (if0.fwd_a_sel !== 2'd1 || if0.fwd_b_sel !== 2'd0) begin bad++; $display("FAIL fwd_mem a=%0d b=%0d exp a=1 b=0", if0.fwd_a_sel, if0.fwd_b_sel); end
    do_reset();
    set_id(1, 1, 1, 2, 1, 0, 1, 0, 0); settle(); tick();        // add x0
    set_id(1, 0, 1, 4, 1, 9, 1, 0, 0); settle(); tick();
    nop(); settle();
    total++; if (if0.fwd_a_sel !== 2'd0) begin bad++; $display("FAIL fwd_x0 got=%0d exp=0", if0.fwd_a_sel); end
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); settle(); tick();
    nop(); settle(); tick();
    set_id(1, 3, 1, 4, 1, 9, 1, 0, 0); settle(); tick();
    nop(); settle();
    total++; if (if0.fwd_a_sel !== 2'd2) begin bad++; $display("FAIL fwd_wb got=%0d exp=2", if0.fwd_a_sel); end
    do_reset();
    set_id(1, 1, 1, 2, 1, 3, 1, 0, 0); settle(); tick();
    set_id(1, 4, 1, 5, 1, 3, 1, 0, 0); settle(); tick();
    set_id(1, 6, 1, 3, 1, 9, 1, 0, 0); settle(); tick();
    nop(); settle();
    total++; if (if0.fwd_b_sel !== 2'd1) begin bad++; $display("FAIL fwd_prio got=%0d exp=1", if0.fwd_b_sel); end
    tick();
  endtask

  task automatic test_multi();
    do_reset();
    set_id(1, 1, 1, 2, 1, 8, 1, 0, 1); settle(); tick();
    nop();
    for (int k = 0; k < 5; k++) begin
      if0.mc_done = (k == 4); settle();
      total++; if (if0.ex_hold !== (k < 4) || if0.pc_en !== (k == 4)) begin
        bad++; $display("FAIL multi_c%0d hold=%b pc=%b exp hold=%b pc=%b", k, if0.ex_hold, if0.pc_en, k < 4, k == 4);
      end
      tick();
    end
    if0.mc_done = 0; settle();
    total++; if (sc[0] !== 16'd4 || if0.ex_hold !== 1'b0) begin bad++; $display("FAIL multi_cnt cnt=%0d hold=%b exp cnt=4 hold=0", sc[0], if0.ex_hold); end
    tick();
  endtask

  task automatic test_branch_lu();
    do_reset();
    set_id(1, 0, 0, 0, 0, 5, 1, 1, 0); settle(); tick();
    set_id(1, 5, 1, 1, 1, 6, 1, 0, 0); if0.ex_branch_taken = 1; settle();
    total++; if (ctl[0][8:4] !== 5'b11110) begin bad++; $display("FAIL br_lu_ctl got=%b exp=11110", ctl[0][8:4]); end
    total++; if (ctl[1][8:4] !== 5'b11110) begin bad++; $display("FAIL br_lu_ctl2 got=%b exp=11110", ctl[1][8:4]); end
    tick(); if0.ex_branch_taken = 0; nop(); settle();
    total++; if (if0.flush_ifid !== 1'b0) begin bad++; $display("FAIL br_once got=%b exp=0", if0.flush_ifid); end
    total++; if (sc[0] !== 16'd0 || fc[0] !== 16'd1) begin bad++; $display("FAIL br_cnt stall=%0d flush=%0d exp stall=0 flush=1", sc[0], fc[0]); end
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_id(1, 1, 1, 2, 1, 8, 1, 0, 1); settle(); tick();
    nop();
    repeat (19) begin settle(); tick(); end
    settle();
    total++; if (sc[2] !== 16'd15) begin bad++; $display("FAIL sat_c4 got=%0d exp=15", sc[2]); end
    total++; if (sc[0] !== 16'd19) begin bad++; $display("FAIL sat_c16 got=%0d exp=19", sc[0]); end
    if0.mc_done = 1; settle(); tick(); if0.mc_done = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
      if0.ex_branch_taken = ($urandom_range(0, 15) == 0);
      if0.mc_done = ($urandom_range(0, 3) == 0);
      settle();
      for (int d = 0; d < 3; d++) begin
        total++; if (ctl[d] !== e_ctl[d]) begin bad++; $display("FAIL rnd_ctl[%0d] cyc=%0d got=%b exp=%b", d, n, ctl[d], e_ctl[d]); end
        total++; if (sc[d] !== 16'(sat(stall_n[d], cw_of(d)))) begin bad++; $display("FAIL rnd_stall[%0d] cyc=%0d got=%0d exp=%0d", d, n, sc[d], sat(stall_n[d], cw_of(d))); end
        total++; if (fc[d] !== 16'(sat(flush_n[d], cw_of(d)))) begin bad++; $display("FAIL rnd_flush[%0d] cyc=%0d got=%0d exp=%0d", d, n, fc[d], sat(flush_n[d], cw_of(d))); end
      end
      tick();
    end
    if0.ex_branch_taken = 0; if0.mc_done = 0; nop();
  endtask

  initial begin
    nop(); if0.ex_branch_taken = 0; if0.mc_done = 0;
    model_reset();
    test_reset();
    test_reset_mid_wait();
    test_load_use();
    test_load_gap();
    test_forward();
    test_multi();
    test_branch_lu();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline hazard and forwarding controller for the 5-stage integer core: IF, ID, EX, MEM, WB.
- Replaces the core's inline load-use compare and forwarding muxes with one sequential block.
- Tracks destination tags for EX, MEM and WB internally, and drives stall, bubble, flush and forward-select signals.
- Adds behaviour the current core lacks: configurable load latency, taken-branch flush, a multi-cycle EX-unit wait state, and saturating performance counters.

Parameters:
- RF_SIZE, 5, register index width.
- LOAD_STALL, 1, bubbles required when a load is immediately followed by a dependent instruction; legal values 1..2.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  RF_SIZE  ID source register 1.
- id_rs2  in  RF_SIZE  ID source register 2.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  RF_SIZE  ID destination register.
- id_reg_write  in  1  ID instruction writes rd.
- id_load  in  1  ID instruction is a load.
- id_multi  in  1  ID instruction uses the multi-cycle EX unit.
- ex_branch_taken  in  1  branch resolved taken in EX this cycle.
- mc_done  in  1  multi-cycle unit result ready this cycle.
- pc_en  out  1  PC advance enable.
- ir_en  out  1  IF/ID register load enable.
- id_bubble  out  1  insert a NOP into ID/EX.
- flush_ifid  out  1  invalidate the IF/ID register.
- ex_hold  out  1  freeze ID/EX contents.
- fwd_a_sel  out  2  EX operand A source: 0 = regfile, 1 = EX/MEM ALU output, 2 = WB data.
- fwd_b_sel  out  2  EX operand B source, same encoding as fwd_a_sel.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of flushes.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to RUN.
  - All tag valid bits, write flags and load flags clear.
  - Both counters clear.
  - Outputs during reset: pc_en=1, ir_en=1, id_bubble=0, flush_ifid=0, ex_hold=0, fwd selects 0.
- Tag pipeline (registered):
  - EX tag: valid, rs1, rs2 (gated by use flags), rd, reg_write, load.
  - MEM tag: rd, reg_write, load.
  - WB tag: rd, reg_write.
  - Tags shift every cycle unless ex_hold=1.
  - When ex_hold=1, EX keeps its tag and MEM receives an invalid tag.
  - When id_bubble=1 or flush, EX receives an invalid tag.
- Forwarding (combinational from EX tag):
  - Select 1 when MEM.reg_write, MEM.rd≠0, MEM.rd equals the source, and MEM not a load.
  - Otherwise select 2 when WB.reg_write, WB.rd≠0 and WB.rd equals the source.
  - Otherwise select 0.
  - MEM has priority over WB.
  - Register 0 is never forwarded.
- Load-use detection:
  - Distance 1: EX valid load, rd≠0, and rd matches a used ID source.
  - Distance 2: only when LOAD_STALL=2; a MEM load matches the same way.
  - Required bubbles: LOAD_STALL for distance 1, 1 for distance 2.
- FSM:
  - RUN → FLUSH on ex_branch_taken, which has the highest priority.
  - RUN → MC_WAIT when the EX tag is valid with the multi flag; the tag stores id_multi.
  - RUN → LD_STALL on load-use detect. Counter loads required−1. The first stall cycle is the detection cycle.
  - LD_STALL: pc_en=0, ir_en=0, id_bubble=1. Decrement each cycle; return to RUN once the counter reaches 0. A taken branch wins and goes to FLUSH.
  - MC_WAIT: pc_en=0, ir_en=0, ex_hold=1. Exit to RUN in the cycle mc_done=1; in that cycle ex_hold=0 and tags advance. A branch cannot be pending in this state.
  - FLUSH: occupies one cycle, asserted combinationally in the detect cycle. flush_ifid=1, id_bubble=1, pc_en=1. Pending load-stall count is discarded. Next state is RUN.
  - When the RUN detect is combinational, stall and flush outputs assert in the same cycle as the detecting condition.
- Counters:
  - stall_count increments every cycle with pc_en=0.
  - flush_count increments per taken branch.
  - Both saturate at all-ones and never wrap.
- Simultaneous events:
  - Branch taken with load-use: flush only, no stall counted.
  - mc_done with no multi op in EX: ignored.
- id_valid=0 suppresses all hazard detection for ID.

Test Plan:
- Reset mid-MC_WAIT (assert rst=0 during wait) → pc_en=1, ex_hold=0, counters 0 immediately, without waiting for a clock edge.
- lw x5 then add x6,x5,x1, LOAD_STALL=1 → exactly 1 cycle with pc_en=0 and id_bubble=1; next cycle fwd_a_sel=2; stall_count=1.
- Same sequence with LOAD_STALL=2 → 2 bubble cycles, stall_count=2. With one unrelated instruction between the load and the add → 1 bubble.
- add x3 back-to-back into a consumer of x3 → fwd_a_sel=1. Same with x0 as destination → fwd_a_sel=0. Same rd in both MEM and WB → MEM chosen.
- Multi op with mc_done after 5 cycles → ex_hold=1 for 4 cycles, stall_count=4, then resume.
- ex_branch_taken together with load-use → flush_ifid=1 for 1 cycle, no stall, flush_count=1.
- Drive 2^CNT_W+3 stall cycles (CNT_W=4) → stall_count holds 15.
